array_divider: RTL and testbench
================================

Name: array_divider

Overview:
- Exact 16-by-8 unsigned restoring array divider built from subtract/mux cells: 8 cascaded rows, one quotient bit per row, MSB first.
- Row output is a 2:1 mux: the trial difference when no borrow occurs, otherwise the restored partial remainder.
- Combinational array; quotient, remainder and overflow flag are registered once at the output.
- Serves as the exact reference block against which the approximate divider variants are compared.

Parameters:
- None. Widths are fixed: dividend 16, divisor 8, quotient 8, remainder 8.

Ports:
- clk  input  1  rising-edge clock for output registers
- rst_n  input  1  asynchronous active-low reset
- x  input  16  unsigned dividend
- y  input  8  unsigned divisor
- bin  input  1  borrow-in injected at the LSB cell of every row (0 for exact division)
- q  output  8  registered quotient
- r  output  8  registered remainder
- ovf  output  1  registered overflow / divide-by-zero flag

Behaviour:
- Reset:
  - rst_n low asynchronously forces q=0, r=0, ovf=0.
  - All three outputs hold 0 until the first rising clk after rst_n deasserts.
- Latency:
  - Inputs are sampled on each rising clk; results appear on q/r/ovf after that edge (1-cycle latency).
  - A new operand is accepted every cycle. There is no handshake.
- Array algorithm (combinational):
  - P starts as x[15:8] (8 bits).
  - For row i = 7 down to 0:
    - T = {P, x[i]} (9 bits).
    - D = T - {1'b0, y} - bin (10-bit arithmetic).
    - If D >= 0 (no borrow out of the row): q[i]=1 and P=D[7:0]. Otherwise q[i]=0 and P=T[7:0].
  - Final remainder r = P after row 0.
- With bin=0, the result is exact: q = x / y and r = x mod y, whenever x[15:8] < y.
- With bin=1, each row subtracts y+1, so q = x / (y+1) and r = x mod (y+1), for x[15:8] < y+1.
  - y=255 with bin=1 uses the full 9-bit subtrahend 256.
- Overflow:
  - ovf=1 when y==0 or x[15:8] >= y + bin (9-bit compare). In that case q=8'hFF and r=8'hFF, overriding the array outputs.
  - Otherwise ovf=0 and q/r come from the array.
- Boundaries:
  - x=0 with y nonzero gives q=0, r=0.
  - If x equals y, both q and r equal... more precisely: x=y (x[15:8]=0) gives q=1, r=0.
  - x < y gives q=0 and r=x[7:0].
  - Maximum legal case: x=16'hFEFF, y=255, bin=0 gives q=255, r=254.
- Async reset asserted mid-stream clears outputs immediately. The in-flight result is discarded.

Test Plan:
- Reset: hold rst_n=0 with x=8, y=4 -> q=0, r=0, ovf=0. Release rst_n, one clk -> q=2, r=0.
- Back-to-back exact divides (bin=0), one per clk, checked one cycle later:
  - 7/3 -> 2 r1
  - 5/5 -> 1 r0
  - 16/4 -> 4 r0
  - 20/5 -> 4 r0
  - 15/3 -> 5 r0
  - 12/5 -> 2 r2
  - 40/13 -> 3 r1
  - 17/5 -> 3 r2
  - 199/7 -> 28 r3
  - 127/5 -> 25 r2
- Edge operands:
  - x=16'hFEFF, y=255 -> q=255, r=254, ovf=0.
  - x=3, y=200 -> q=0, r=3.
- Overflow:
  - y=0, x=8 -> ovf=1, q=8'hFF, r=8'hFF.
  - x=16'h0500, y=5 -> ovf=1, q=8'hFF, r=8'hFF.
- Borrow-in: bin=1, x=8, y=4 -> q=1, r=3. bin=1, x=199, y=6 -> q=28, r=3.
- Reset mid-stream: assert rst_n=0 between clk edges while streaming -> outputs drop to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/array_divider.sv
// Exact 16-by-8 unsigned restoring array divider: eight subtract/mux rows,
// one quotient bit per row, with quotient, remainder and overflow registered once.
module array_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    input  logic        bin,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf
);

    // One array row: {quotient bit, next partial remainder}. A borrow shows up as D[9].
    function automatic logic [8:0] row_step(
        input logic [7:0] p,
        input logic       xb,
        input logic [7:0] d,
        input logic       b
    );
        logic [8:0] t;
        logic [9:0] diff;
        t    = {p, xb};
        diff = {1'b0, t} - {2'b00, d} - {9'd0, b};
        if (diff[9] == 1'b0) begin
            row_step = {1'b1, diff[7:0]};
        end else begin
            row_step = {1'b0, t[7:0]};
        end
    endfunction

    logic [7:0] quo_s;
    logic [7:0] rem_s;
    logic [8:0] step_s;
    logic       ovf_s;

    // Cascade of the eight rows, MSB first, plus the overflow / divide-by-zero detect.
    always_comb begin
        quo_s  = 8'd0;
        rem_s  = x[15:8];
        step_s = 9'd0;
        for (int i = 7; i >= 0; i--) begin
            step_s   = row_step(rem_s, x[i], y, bin);
            quo_s[i] = step_s[8];
            rem_s    = step_s[7:0];
        end
        if ((y == 8'd0) || ({1'b0, x[15:8]} >= ({1'b0, y} + {8'd0, bin}))) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Output registers; overflow saturates both results to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 8'd0;
            r   <= 8'd0;
            ovf <= 1'b0;
        end else if (ovf_s) begin
            q   <= 8'hFF;
            r   <= 8'hFF;
            ovf <= 1'b1;
        end else begin
            q   <= quo_s;
            r   <= rem_s;
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_array_divider.sv
// Self-checking bench for array_divider: expected results are queued when operands
// are driven and popped when the registered outputs appear one clock later.
module tb_array_divider;

    logic        clk;
    logic        rst_n;
    logic [15:0] x;
    logic [7:0]  y;
    logic        bin;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    array_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .q     (q),
        .r     (r),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set on the falling edge and queue its expected result.
    task automatic push_op(input logic [15:0] xv, input logic [7:0] yv, input logic bv,
                           input logic [7:0] eq, input logic [7:0] er, input logic eo,
                           input string nm);
        exp_t t;
        @(negedge clk);
        x   = xv;
        y   = yv;
        bin = bv;
        t.q = eq; t.r = er; t.ovf = eo; t.name = nm;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x = 16'd8; y = 8'd4; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q, r, ovf} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: q=%0d r=%0d ovf=%0d expected q=0 r=0 ovf=0", q, r, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({q, r, ovf} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_before_edge: q=%0d r=%0d ovf=%0d expected 0 0 0", q, r, ovf);
        end
        sb.push_back('{8'd2, 8'd0, 1'b0, "reset_first_op"});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
            errors++;
            $display("FAIL %s: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                     e.name, q, r, ovf, e.q, e.r, e.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int xs [10] = '{7, 5, 16, 20, 15, 12, 40, 17, 199, 127};
        int ys [10] = '{3, 5, 4, 5, 3, 5, 13, 5, 7, 5};
        int qs [10] = '{2, 1, 4, 4, 5, 2, 3, 3, 28, 25};
        int rs [10] = '{1, 0, 0, 0, 0, 2, 1, 2, 3, 2};
        for (int i = 0; i < 10; i++) begin
            push_op(16'(xs[i]), 8'(ys[i]), 1'b0, 8'(qs[i]), 8'(rs[i]), 1'b0,
                    $sformatf("b2b_%0d", i));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_empty: scoreboard has 0 entries, expected 1");
            end else begin
                e = sb.pop_front();
                checks++;
                if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
                    errors++;
                    $display("FAIL %s: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                             e.name, q, r, ovf, e.q, e.r, e.ovf);
                end
            end
        end
    endtask

    task automatic test_edges_and_overflow();
        logic [15:0] xs [6] = '{16'hFEFF, 16'd3, 16'd8, 16'h0500, 16'd8, 16'd199};
        logic [7:0]  ys [6] = '{8'd255, 8'd200, 8'd0, 8'd5, 8'd4, 8'd6};
        logic        bs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  qs [6] = '{8'd255, 8'd0, 8'hFF, 8'hFF, 8'd1, 8'd28};
        logic [7:0]  rs [6] = '{8'd254, 8'd3, 8'hFF, 8'hFF, 8'd3, 8'd3};
        logic        os [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_op(xs[i], ys[i], bs[i], qs[i], rs[i], os[i], $sformatf("edge_%0d", i));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
                errors++;
                $display("FAIL %s: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                         e.name, q, r, ovf, e.q, e.r, e.ovf);
            end
        end
    endtask

    // Random operands against an integer-division model of the divider.
    task automatic test_random();
        logic [15:0] xv;
        logic [7:0]  yv;
        logic        bv;
        int          d;
        for (int i = 0; i < 300; i++) begin
            yv = 8'($urandom_range(0, 255));
            bv = 1'($urandom_range(0, 1));
            xv = 16'($urandom);
            if (i % 4 != 0) xv[15:8] = 8'($urandom_range(0, (yv == 8'd0) ? 0 : int'(yv) - 1));
            d = int'(yv) + int'(bv);
            if (yv == 8'd0 || int'(xv[15:8]) >= d)
                push_op(xv, yv, bv, 8'hFF, 8'hFF, 1'b1, $sformatf("rand_%0d", i));
            else
                push_op(xv, yv, bv, 8'(int'(xv) / d), 8'(int'(xv) % d), 1'b0,
                        $sformatf("rand_%0d", i));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
                errors++;
                $display("FAIL %s x=%0d y=%0d bin=%0d: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                         e.name, xv, yv, bv, q, r, ovf, e.q, e.r, e.ovf);
            end
        end
    endtask

    task automatic test_reset_midstream();
        push_op(16'd199, 8'd7, 1'b0, 8'd28, 8'd3, 1'b0, "mid_pre");
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
            errors++;
            $display("FAIL %s: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                     e.name, q, r, ovf, e.q, e.r, e.ovf);
        end
        x = 16'd127; y = 8'd5;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q, r, ovf} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_midstream_async: q=%0d r=%0d ovf=%0d expected 0 0 0", q, r, ovf);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_op(16'd40, 8'd13, 1'b0, 8'd3, 8'd1, 1'b0, "mid_post");
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({q, r, ovf} !== {e.q, e.r, e.ovf}) begin
            errors++;
            $display("FAIL %s: q=%0d r=%0d ovf=%0d expected q=%0d r=%0d ovf=%0d",
                     e.name, q, r, ovf, e.q, e.r, e.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_edges_and_overflow();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
